// File: rtl/emu_scan_ctrl_if.sv
// Command, dump-stream and restore-stream handshakes of the checkpoint
// scan controller. The controller takes the slave side and the host takes
// the master side.
interface emu_scan_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;

  modport slave (
    input  cmd_valid, cmd_dir, out_ready, in_valid, in_data,
    output cmd_ready, out_valid, out_data, out_last, in_ready
  );

  modport master (
    output cmd_valid, cmd_dir, out_ready, in_valid, in_data,
    input  cmd_ready, out_valid, out_data, out_last, in_ready
  );
endinterface

// File: rtl/emu_scan_ctrl.sv
// Checkpoint scan controller for an emulated design: pauses the DUT clock,
// streams the FF scan chain and the RAM scan chain out (dump) or in
// (restore), then releases the pause and pulses done.
// RAM words pass through a staging FIFO because the RAM chain cannot stall.
// Optional: define EMU_SCAN_CTRL_CSUM_EN to add a 64-bit XOR checksum port.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready high
// PAUSE     | one cycle of DUT pause before scanning starts
// FF_SCAN   | one FF word per stream handshake
// RAM_FILL  | restore: stage MEM_WORDS words in the FIFO
// RAM_PRE   | dump: two cycles of RAM chain read latency
// RAM_SCAN  | MEM_WORDS contiguous RAM chain cycles
// RAM_POST  | restore: one extra shift cycle to commit the last word
// RAM_END   | one cycle with ram_se low, pause still high
// DRAIN     | dump: pause released, emptying the FIFO to the stream
// FINISH    | done pulse, back to IDLE
module emu_scan_ctrl #(
  parameter int FF_WORDS   = 4,
  parameter int MEM_WORDS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  emu_scan_ctrl_if.slave bus,
  output logic          pause,
  output logic          done,
  output logic          ff_se,
  output logic          ff_dir,
  output logic [63:0]   ff_sdi,
  input  logic [63:0]   ff_sdo,
  output logic          ram_se,
  output logic          ram_sd,
  output logic [63:0]   ram_sdi,
  input  logic [63:0]   ram_sdo
`ifdef EMU_SCAN_CTRL_CSUM_EN
  ,
  output logic [63:0]   csum
`endif
);

  if (FIFO_DEPTH < MEM_WORDS) begin : g_bad_depth
    $error("emu_scan_ctrl: FIFO_DEPTH must be >= MEM_WORDS");
  end

  localparam int CNT_MAX = (FF_WORDS > MEM_WORDS + 2) ? FF_WORDS : MEM_WORDS + 2;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW      = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] FF_TC   = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] MEM_TC  = CW'(MEM_WORDS - 1);
  localparam logic [CW-1:0] PRE_TC  = CW'(1);
  localparam logic [FW-1:0] FILL_TC = FW'(MEM_WORDS - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PAUSE    = 4'd1;
  localparam logic [3:0] S_FF_SCAN  = 4'd2;
  localparam logic [3:0] S_RAM_FILL = 4'd3;
  localparam logic [3:0] S_RAM_PRE  = 4'd4;
  localparam logic [3:0] S_RAM_SCAN = 4'd5;
  localparam logic [3:0] S_RAM_POST = 4'd6;
  localparam logic [3:0] S_RAM_END  = 4'd7;
  localparam logic [3:0] S_DRAIN    = 4'd8;
  localparam logic [3:0] S_FINISH   = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q;
  logic          accept;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [FW-1:0] fcnt_q;
  logic          fifo_empty;
  logic          push, pop;
  logic [63:0]   push_data;
  logic [63:0]   head;
  logic          step;
  logic          drain;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = (state_q == S_IDLE) && bus.cmd_valid;
  assign fifo_empty = (fcnt_q == '0);
  assign head       = mem[rd_q];

  // State register, word counter and the direction latched at command accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) dir_q <= bus.cmd_dir;
    end
  end

  // FIFO bookkeeping; a new command also flushes anything left by an abort.
  always_ff @(posedge clk) begin
    if (!rstn || accept) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      fcnt_q <= fcnt_q + FW'(push) - FW'(pop);
    end
  end

  // FIFO storage, no reset needed since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_data;
  end

  // Next state and all chain/stream outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.cmd_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.in_ready  = 1'b0;
    done          = 1'b0;
    ff_se         = 1'b0;
    ff_sdi        = '0;
    ram_se        = 1'b0;
    ram_sd        = 1'b0;
    ram_sdi       = '0;
    push          = 1'b0;
    pop           = 1'b0;
    push_data     = '0;
    step          = 1'b0;
    pause         = (state_q >= S_PAUSE) && (state_q <= S_RAM_END);
    ff_dir        = (state_q == S_FF_SCAN) && dir_q;

    // Dumped RAM words leave the FIFO from the first scan cycle onward.
    // The last word can only be at the head once pushing has stopped.
    drain = !dir_q && ((state_q == S_RAM_SCAN) || (state_q == S_RAM_END) ||
                       (state_q == S_DRAIN));
    if (drain) begin
      bus.out_valid = !fifo_empty;
      bus.out_data  = head;
      bus.out_last  = !fifo_empty && (fcnt_q == FW'(1)) && (state_q != S_RAM_SCAN);
      pop           = !fifo_empty && bus.out_ready;
    end

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_d = S_PAUSE;
          cnt_d   = '0;
        end
      end
      S_PAUSE: begin
        state_d = S_FF_SCAN;
        cnt_d   = '0;
      end
      S_FF_SCAN: begin
        if (!dir_q) begin
          bus.out_valid = 1'b1;
          bus.out_data  = ff_sdo;
          ff_se         = bus.out_ready;
          step          = bus.out_ready;
        end else begin
          bus.in_ready = 1'b1;
          ff_sdi       = bus.in_data;
          ff_se        = bus.in_valid;
          step         = bus.in_valid;
        end
        if (step) begin
          if (cnt_q == FF_TC) begin
            state_d = dir_q ? S_RAM_FILL : S_RAM_PRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RAM_FILL: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          push      = 1'b1;
          push_data = bus.in_data;
          if (fcnt_q == FILL_TC) begin
            state_d = S_RAM_SCAN;
            cnt_d   = '0;
          end
        end
      end
      S_RAM_PRE: begin
        ram_se = 1'b1;
        if (cnt_q == PRE_TC) begin
          state_d = S_RAM_SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RAM_SCAN: begin
        ram_se = 1'b1;
        if (dir_q) begin
          ram_sd  = 1'b1;
          ram_sdi = head;
          pop     = 1'b1;
        end else begin
          push      = 1'b1;
          push_data = ram_sdo;
        end
        if (cnt_q == MEM_TC) begin
          state_d = dir_q ? S_RAM_POST : S_RAM_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RAM_POST: begin
        ram_se  = 1'b1;
        ram_sd  = 1'b1;
        state_d = S_RAM_END;
      end
      S_RAM_END: begin
        state_d = dir_q ? S_FINISH : S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty || (pop && bus.out_last)) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef EMU_SCAN_CTRL_CSUM_EN
  // Running XOR of every word moved on either stream by the current operation.
  always_ff @(posedge clk) begin
    if (!rstn || accept) begin
      csum <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      csum <= csum ^ bus.out_data;
    end else if (bus.in_valid && bus.in_ready) begin
      csum <= csum ^ bus.in_data;
    end
  end
`endif

endmodule
